sweep_sequencer: RTL and testbench

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

---
 rtl/sweep_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// Frequency-sweep sequencer: tunes the synthesizer to each point, waits for lock
// and settle, triggers a capture, then hands the result to the host before moving on.
module sweep_sequencer #(
   parameter int PNT_W       = 12,
   parameter int SETTLE_W    = 16,
   parameter int ACK_TIMEOUT = 65535
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [PNT_W-1:0]    cfg_points,
   input  logic [SETTLE_W-1:0] cfg_settle,
   output logic                synth_req,
   output logic [PNT_W-1:0]    synth_idx,
   input  logic                synth_ack,
   output logic                conv_start,
   input  logic                conv_done,
   output logic                rd_req,
   input  logic                rd_ack,
   output logic                busy,
   output logic [PNT_W-1:0]    point_idx,
   output logic                sweep_done,
   output logic                err_timeout
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TUNE      = 3'd1,
      S_SETTLE    = 3'd2,
      S_CONV      = 3'd3,
      S_WAIT_CONV = 3'd4,
      S_READOUT   = 3'd5,
      S_NEXT      = 3'd6,
      S_DONE      = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [PNT_W-1:0]    points_q, points_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [PNT_W-1:0]    point_idx_q, point_idx_d;
   logic [TO_W-1:0]     ack_cnt_q, ack_cnt_d;
   logic                conv_first_q, conv_first_d;
   logic                err_timeout_q, err_timeout_d;
   logic                busy_q, busy_d;
   logic                synth_req_q, synth_req_d;
   logic [PNT_W-1:0]    synth_idx_q, synth_idx_d;
   logic                conv_start_q, conv_start_d;
   logic                rd_req_q, rd_req_d;
   logic                sweep_done_q, sweep_done_d;
   logic                abort_hit_s;
   logic [PNT_W:0]      idx_inc_s;

   assign abort_hit_s = abort && (state_q != S_IDLE);
   assign idx_inc_s   = {1'b0, point_idx_q} + (PNT_W + 1)'(1);

   // Next-state and datapath updates; abort overrides every in-sweep event.
   always_comb begin
      state_d       = state_q;
      points_d      = points_q;
      settle_d      = settle_q;
      settle_cnt_d  = settle_cnt_q;
      point_idx_d   = point_idx_q;
      ack_cnt_d     = ack_cnt_q;
      conv_first_d  = conv_first_q;
      err_timeout_d = err_timeout_q;
      if (abort_hit_s) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_d       = S_TUNE;
                  points_d      = (cfg_points == '0) ? PNT_W'(1) : cfg_points;
                  settle_d      = cfg_settle;
                  point_idx_d   = '0;
                  ack_cnt_d     = '0;
                  err_timeout_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_TUNE: begin
               if (synth_ack) begin
                  if (settle_q == '0) begin
                     state_d = S_CONV;
                  end else begin
                     state_d      = S_SETTLE;
                     settle_cnt_d = settle_q - SETTLE_W'(1);
                  end
               end else if (ack_cnt_q == TO_LAST) begin
                  state_d       = S_IDLE;
                  err_timeout_d = 1'b1;
               end else begin
                  ack_cnt_d = ack_cnt_q + TO_W'(1);
               end
            end
            S_SETTLE: begin
               if (settle_cnt_q == '0) begin
                  state_d = S_CONV;
               end else begin
                  settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
               end
            end
            S_CONV: begin
               state_d      = S_WAIT_CONV;
               conv_first_d = 1'b1;
            end
            // The capture block's done flag is stale for one cycle after conv_start.
            S_WAIT_CONV: begin
               if (conv_first_q) begin
                  conv_first_d = 1'b0;
               end else if (conv_done) begin
                  state_d = S_READOUT;
               end else begin
                  state_d = S_WAIT_CONV;
               end
            end
            S_READOUT: begin
               if (rd_ack) begin
                  state_d = S_NEXT;
               end else begin
                  state_d = S_READOUT;
               end
            end
            S_NEXT: begin
               if (idx_inc_s == {1'b0, points_q}) begin
                  state_d = S_DONE;
               end else begin
                  state_d     = S_TUNE;
                  point_idx_d = idx_inc_s[PNT_W-1:0];
                  ack_cnt_d   = '0;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d       = (state_d != S_IDLE);
      synth_req_d  = (state_d == S_TUNE);
      conv_start_d = (state_d == S_CONV);
      rd_req_d     = (state_d == S_READOUT);
      sweep_done_d = (state_d == S_DONE);
      synth_idx_d  = point_idx_d;
   end

   // State, datapath and registered-output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         points_q      <= PNT_W'(1);
         settle_q      <= '0;
         settle_cnt_q  <= '0;
         point_idx_q   <= '0;
         ack_cnt_q     <= '0;
         conv_first_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         synth_req_q   <= 1'b0;
         synth_idx_q   <= '0;
         conv_start_q  <= 1'b0;
         rd_req_q      <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         points_q      <= points_d;
         settle_q      <= settle_d;
         settle_cnt_q  <= settle_cnt_d;
         point_idx_q   <= point_idx_d;
         ack_cnt_q     <= ack_cnt_d;
         conv_first_q  <= conv_first_d;
         err_timeout_q <= err_timeout_d;
         busy_q        <= busy_d;
         synth_req_q   <= synth_req_d;
         synth_idx_q   <= synth_idx_d;
         conv_start_q  <= conv_start_d;
         rd_req_q      <= rd_req_d;
         sweep_done_q  <= sweep_done_d;
      end
   end

   assign busy        = busy_q;
   assign synth_req   = synth_req_q;
   assign synth_idx   = synth_idx_q;
   assign conv_start  = conv_start_q;
   assign rd_req      = rd_req_q;
   assign sweep_done  = sweep_done_q;
   assign err_timeout = err_timeout_q;
   assign point_idx   = point_idx_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: a negedge responder plays synthesizer,
// capture block and host, and sweep outcomes are compared with a timing-level model.
module tb_sweep_sequencer;

   localparam int PW = 12;
   localparam int SW = 16;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [PW-1:0] cfg_points;
   logic [SW-1:0] cfg_settle;
   logic          synth_req, synth_ack, conv_start, conv_done, rd_req, rd_ack;
   logic [PW-1:0] synth_idx, point_idx;
   logic          busy, sweep_done, err_timeout;

   sweep_sequencer #(.PNT_W(PW), .SETTLE_W(SW), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_points(cfg_points), .cfg_settle(cfg_settle),
      .synth_req(synth_req), .synth_idx(synth_idx), .synth_ack(synth_ack),
      .conv_start(conv_start), .conv_done(conv_done),
      .rd_req(rd_req), .rd_ack(rd_ack),
      .busy(busy), .point_idx(point_idx), .sweep_done(sweep_done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Responder knobs and event logs
   int ack_dly = 2, conv_dly = 10, rd_dly = 5, rd_blk = -1;
   bit ack_en = 1'b1, conv_hold = 1'b0, noise = 1'b0, rd_force = 1'b0;
   int req_cnt = 0, conv_cnt = 0, rd_cnt = 0, done_cnt = 0;
   bit conv_armed = 1'b0, rd_prev = 1'b0;
   int ack_q[$], idx_q[$], conv_q[$], rd_q[$];

   // Peripheral models: drive acknowledges on the falling edge and log events.
   always @(negedge clk) begin
      if (synth_req === 1'b1) req_cnt++; else req_cnt = 0;
      if (synth_req === 1'b1) synth_ack = ack_en && (req_cnt == ack_dly);
      else synth_ack = noise && ($urandom_range(0, 3) == 0);
      if (synth_req === 1'b1 && synth_ack) begin
         ack_q.push_back(cyc);
         idx_q.push_back(int'(synth_idx));
      end
      if (conv_start === 1'b1) begin
         conv_q.push_back(cyc);
         conv_cnt   = 0;
         conv_armed = 1'b1;
      end else begin
         conv_cnt++;
      end
      conv_done = conv_hold || (conv_armed && conv_cnt >= conv_dly);
      if (rd_req === 1'b1 && !rd_prev) rd_q.push_back(cyc);
      rd_prev = (rd_req === 1'b1);
      if (rd_req === 1'b1) rd_cnt++; else rd_cnt = 0;
      if (rd_req === 1'b1) rd_ack = rd_force || (rd_cnt == rd_dly && int'(point_idx) != rd_blk);
      else rd_ack = rd_force || (noise && ($urandom_range(0, 3) == 0));
      if (sweep_done === 1'b1) done_cnt++;
   end

   task automatic run_sweep(input int n, input int s);
      int neff, poke, exp_rd;
      bit got;
      neff = (n == 0) ? 1 : n;
      exp_rd = conv_hold ? 3 : ((conv_dly + 1 > 3) ? conv_dly + 1 : 3);
      ack_q.delete(); idx_q.delete(); conv_q.delete(); rd_q.delete();
      done_cnt   = 0;
      cfg_points = PW'(n);
      cfg_settle = SW'(s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_points = PW'($urandom);
      cfg_settle = SW'($urandom_range(0, 50));
      poke = int'($urandom_range(2, 40));
      got  = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (done_cnt > 0) begin
            got = 1'b1;
            break;
         end
         start = (k == poke) && busy;
         @(negedge clk);
      end
      start = 1'b0;
      check_val("sweep_done_seen", 32'(got), 32'd1);
      @(negedge clk);
      check_val("busy_after_sweep", 32'(busy), 32'd0);
      check_val("final_point_idx", 32'(point_idx), 32'(neff - 1));
      check_val("done_pulses", 32'(done_cnt), 32'd1);
      check_val("conv_pulses", 32'(conv_q.size()), 32'(neff));
      check_val("tune_acks", 32'(ack_q.size()), 32'(neff));
      for (int i = 0; i < neff; i++) begin
         if (i < conv_q.size() && i < ack_q.size() && i < rd_q.size()) begin
            check_val("synth_idx", 32'(idx_q[i]), 32'(i));
            check_val("settle_gap", 32'(conv_q[i] - ack_q[i]), 32'(s + 1));
            check_val("conv_to_rd", 32'(rd_q[i] - conv_q[i]), 32'(exp_rd));
         end
      end
   endtask

   initial begin
      int cnt;
      bit found;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_points = '0; cfg_settle = '0;
      repeat (3) @(negedge clk);
      check_val("reset_outputs", 32'({busy, synth_req, conv_start, rd_req, sweep_done,
                                      err_timeout, point_idx, synth_idx}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_sweep(3, 4);
      ack_dly = 1; conv_dly = 3; rd_dly = 1;
      run_sweep(0, 0);
      conv_hold = 1'b1;
      run_sweep(2, 1);
      conv_hold = 1'b0;

      // Synthesizer never locks
      ack_en = 1'b0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (!busy) break;
         if (synth_req) cnt++;
         @(negedge clk);
      end
      check_val("timeout_tune_cycles", 32'(cnt), 32'(TO));
      check_val("timeout_err", 32'(err_timeout), 32'd1);
      check_val("timeout_req_low", 32'(synth_req), 32'd0);
      @(negedge clk);
      check_val("timeout_err_sticky", 32'(err_timeout), 32'd1);
      ack_en = 1'b1;
      cfg_points = PW'(1); cfg_settle = SW'(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("err_cleared_by_start", 32'(err_timeout), 32'd0);
      check_val("busy_after_start", 32'(busy), 32'd1);
      for (int k = 0; k < 500; k++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check_val("restart_finished", 32'(busy), 32'd0);

      // Abort in READOUT of point 1 out of 4
      rd_blk = 1; ack_dly = 2; conv_dly = 4; rd_dly = 2;
      cfg_points = PW'(4); cfg_settle = SW'(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (rd_req && int'(point_idx) == 1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val("abort_point_reached", 32'(found), 32'd1);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_rd_req", 32'(rd_req), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      rd_blk = -1;
      rd_force = 1'b1;
      repeat (2) @(negedge clk);
      rd_force = 1'b0;
      repeat (3) @(negedge clk);
      check_val("late_rd_ack_busy", 32'(busy), 32'd0);
      check_val("abort_no_done", 32'(done_cnt), 32'd0);

      // start together with abort while idle
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_val("start_abort_idle", 32'(busy), 32'd0);

      // Reset during WAIT_CONV with capture done asserted
      conv_hold = 1'b1;
      cfg_points = PW'(3); cfg_settle = SW'(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (conv_start && int'(point_idx) == 1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val("wait_conv_reached", 32'(found), 32'd1);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      check_val("midsweep_reset", 32'({busy, synth_req, conv_start, rd_req, sweep_done,
                                       err_timeout, point_idx, synth_idx}), 32'd0);
      check_val("reset_no_done", 32'(done_cnt), 32'd0);
      rst = 1'b0; start = 1'b0; abort = 1'b0; conv_hold = 1'b0;
      @(negedge clk);
      check_val("idle_after_reset", 32'(busy), 32'd0);

      // Randomized sweeps with spurious handshake noise
      noise = 1'b1;
      repeat (8) begin
         ack_dly   = int'($urandom_range(1, 5));
         conv_dly  = int'($urandom_range(0, 12));
         rd_dly    = int'($urandom_range(1, 5));
         conv_hold = ($urandom_range(0, 3) == 0);
         run_sweep(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
